// File: rtl/register_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : register_writeback_unit
//  Purpose  : Merges ALU and load results into one register-file write per
//             cycle and tracks pending writes in a hazard scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module register_writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  input  logic [3:0]  iss_rd,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [15:0] alu_data,
  input  logic        mem_valid,
  input  logic [3:0]  mem_rd,
  input  logic [15:0] mem_data,
  output logic        alu_full,
  output logic [1:0]  fifo_count,
  output logic [15:0] en,
  output logic [15:0] wb_data,
  output logic [15:0] busy,
  output logic        err
);

  localparam logic [1:0] c_FIFO_DEPTH = 2'd2;

  logic [3:0]  r_fifo_rd   [0:1];
  logic [15:0] r_fifo_data [0:1];
  logic [1:0]  r_count;
  logic [15:0] r_en;
  logic [15:0] r_wb_data;
  logic [15:0] r_busy;
  logic        r_err;

  logic        w_fifo_empty;
  logic        w_full;
  logic        w_sel_mem;
  logic        w_sel_fifo;
  logic        w_sel_alu;
  logic        w_sel_any;
  logic [3:0]  w_sel_rd;
  logic [15:0] w_sel_data;
  logic        w_pop;
  logic        w_push;
  logic        w_overflow;
  logic        w_wr_idx;
  logic [15:0] w_wr_mask;
  logic [15:0] w_iss_mask;
  logic [1:0]  w_count_next;

  assign w_fifo_empty = (r_count == 2'd0);
  assign w_full       = (r_count == c_FIFO_DEPTH);

  // Loads always win; the FIFO drains before any new ALU result may bypass it.
  assign w_sel_mem  = mem_valid;
  assign w_sel_fifo = !mem_valid && !w_fifo_empty;
  assign w_sel_alu  = !mem_valid && w_fifo_empty && alu_valid;
  assign w_sel_any  = w_sel_mem || w_sel_fifo || w_sel_alu;

  always_comb begin
    w_sel_rd   = alu_rd;
    w_sel_data = alu_data;
    if (w_sel_mem) begin
      w_sel_rd   = mem_rd;
      w_sel_data = mem_data;
    end else if (w_sel_fifo) begin
      w_sel_rd   = r_fifo_rd[0];
      w_sel_data = r_fifo_data[0];
    end
  end

  assign w_pop      = w_sel_fifo;
  assign w_overflow = alu_valid && w_full && !w_pop;
  assign w_push     = alu_valid && (mem_valid || !w_fifo_empty) && !w_overflow;

  // Slot that receives a pushed entry once the head has (possibly) shifted out.
  assign w_wr_idx = w_full || ((r_count == 2'd1) && !w_pop);

  assign w_wr_mask  = w_sel_any ? (16'd1 << w_sel_rd) : 16'd0;
  assign w_iss_mask = iss_valid ? (16'd1 << iss_rd)   : 16'd0;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage needs no reset: occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_fifo_rd[0]   <= r_fifo_rd[1];
      r_fifo_data[0] <= r_fifo_data[1];
    end
    if (w_push) begin
      r_fifo_rd[w_wr_idx]   <= alu_rd;
      r_fifo_data[w_wr_idx] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= 2'd0;
      r_en      <= 16'd0;
      r_wb_data <= 16'd0;
      r_busy    <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_en    <= w_wr_mask;
      if (w_sel_any) begin
        r_wb_data <= w_sel_data;
      end
      // Set is applied after clear so a same-edge reissue stays pending.
      r_busy <= (r_busy & ~w_wr_mask) | w_iss_mask;
      if (w_overflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign alu_full   = (r_count == c_FIFO_DEPTH);
  assign fifo_count = r_count;
  assign en         = r_en;
  assign wb_data    = r_wb_data;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_register_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_writeback_unit
//  Purpose  : Directed and random checks of register_writeback_unit against a
//             queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_writeback_unit;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [3:0]  iss_rd;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        alu_full;
  logic [1:0]  fifo_count;
  logic [15:0] en;
  logic [15:0] wb_data;
  logic [15:0] busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_en;
  logic [15:0] m_wb;
  logic [15:0] m_busy;
  logic        m_err;

  register_writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .alu_full   (alu_full),
    .fifo_count (fifo_count),
    .en         (en),
    .wb_data    (wb_data),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en   = 16'd0;
    m_wb   = 16'd0;
    m_busy = 16'd0;
    m_err  = 1'b0;
  endtask

  // Reference: one write per edge, loads first, then oldest queued ALU result,
  // then a fresh ALU result only when nothing is queued.
  task automatic model_step();
    int          s0;
    bit          wrote;
    bit          popped;
    logic [3:0]  wrd;
    logic [15:0] wd;
    ent_t        e;
    if (!rst) begin
      model_reset();
      return;
    end
    s0 = q.size();
    wrote = 0;
    popped = 0;
    wrd = 4'd0;
    wd = 16'd0;
    if (mem_valid) begin
      wrd = mem_rd; wd = mem_data; wrote = 1;
    end else if (s0 > 0) begin
      e = q.pop_front();
      wrd = e.rd; wd = e.d; wrote = 1; popped = 1;
    end else if (alu_valid) begin
      wrd = alu_rd; wd = alu_data; wrote = 1;
    end
    if (alu_valid && (mem_valid || s0 > 0)) begin
      if (s0 == 2 && !popped) m_err = 1'b1;
      else q.push_back({alu_rd, alu_data});
    end
    m_en = 16'd0;
    if (wrote) begin
      m_en[wrd] = 1'b1;
      m_wb = wd;
      m_busy[wrd] = 1'b0;
    end
    if (iss_valid) m_busy[iss_rd] = 1'b1;
  endtask

  task automatic check_all();
    chk("en", en, m_en);
    chk("wb_data", wb_data, m_wb);
    chk("busy", busy, m_busy);
    chk("fifo_count", {14'd0, fifo_count}, 16'(q.size()));
    chk("alu_full", {15'd0, alu_full}, {15'd0, (q.size() == 2)});
    chk("err", {15'd0, err}, {15'd0, m_err});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd = 4'd0;
    alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 16'd0;
    mem_valid = 1'b0; mem_rd = 4'd0; mem_data = 16'd0;
  endtask

  task automatic randomize_inputs();
    iss_valid = 1'($urandom_range(0, 1));
    iss_rd    = 4'($urandom);
    alu_valid = ($urandom_range(0, 2) != 0);
    alu_rd    = 4'($urandom);
    alu_data  = 16'($urandom);
    mem_valid = ($urandom_range(0, 3) == 0);
    mem_rd    = 4'($urandom);
    mem_data  = 16'($urandom);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();

    // Reset held with random activity
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      tick();
    end
    chk("rst_en", en, 16'h0000);
    chk("rst_busy", busy, 16'h0000);
    chk("rst_count", {14'd0, fifo_count}, 16'd0);
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_en", en, 16'h0000);
    chk("post_rst_wb", wb_data, 16'h0000);

    // ALU bypass
    iss_valid = 1'b1; iss_rd = 4'd3;
    tick();
    chk("bypass_busy3_set", {15'd0, busy[3]}, 16'd1);
    idle();
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h0123;
    tick();
    chk("bypass_en", en, 16'h0008);
    chk("bypass_wb", wb_data, 16'h0123);
    chk("bypass_busy3_clr", {15'd0, busy[3]}, 16'd0);

    // Load/ALU collision
    idle();
    mem_valid = 1'b1; mem_rd = 4'd7;  mem_data = 16'h4545;
    alu_valid = 1'b1; alu_rd = 4'd15; alu_data = 16'hAEAE;
    tick();
    chk("coll_en1", en, 16'h0080);
    chk("coll_wb1", wb_data, 16'h4545);
    chk("coll_cnt1", {14'd0, fifo_count}, 16'd1);
    idle();
    tick();
    chk("coll_en2", en, 16'h8000);
    chk("coll_wb2", wb_data, 16'hAEAE);
    chk("coll_cnt2", {14'd0, fifo_count}, 16'd0);

    // Ordering and overflow behind three consecutive loads
    mem_valid = 1'b1; mem_rd = 4'd8; mem_data = 16'h1111;
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'h0001;
    tick();
    mem_data = 16'h2222; alu_rd = 4'd2; alu_data = 16'h0002;
    tick();
    chk("ovf_full", {15'd0, alu_full}, 16'd1);
    mem_data = 16'h3333; alu_rd = 4'd4; alu_data = 16'h0004;
    tick();
    chk("ovf_err", {15'd0, err}, 16'd1);
    chk("ovf_cnt", {14'd0, fifo_count}, 16'd2);
    idle();
    tick();
    chk("ord_en1", en, 16'h0002);
    tick();
    chk("ord_en2", en, 16'h0004);
    tick();
    chk("ord_en3", en, 16'h0000);

    // Scoreboard set/clear on the same edge
    iss_valid = 1'b1; iss_rd = 4'd5;
    tick();
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 16'h5555;
    tick();
    chk("sb_en", en, 16'h0020);
    chk("sb_busy5", {15'd0, busy[5]}, 16'd1);
    idle();
    tick();

    // Async reset with a full FIFO and pending busy bits
    rst = 1'b0; tick(); rst = 1'b1; tick();
    iss_valid = 1'b1; iss_rd = 4'd5;
    mem_valid = 1'b1; mem_rd = 4'd0; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'hBBBB;
    tick();
    iss_rd = 4'd7; alu_rd = 4'd2; alu_data = 16'hCCCC;
    tick();
    idle();
    chk("pre_arst_cnt", {14'd0, fifo_count}, 16'd2);
    chk("pre_arst_busy", busy, 16'h00A0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_en", en, 16'h0000);
    chk("arst_wb", wb_data, 16'h0000);
    chk("arst_busy", busy, 16'h0000);
    chk("arst_cnt", {14'd0, fifo_count}, 16'd0);
    chk("arst_full", {15'd0, alu_full}, 16'd0);
    chk("arst_err", {15'd0, err}, 16'd0);
    tick();
    rst = 1'b1;
    tick();

    // Randomized traffic against the model, with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      rst = (i != 200);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_writeback_unit.md
# register_writeback_unit

Write-side companion to the register fetch unit. It accepts results from the ALU (single-cycle) and the memory load path (variable latency). It serializes them into at most one register-file write per cycle by driving a one-hot enable and write data into the 16×16 register file. It also keeps a pending-write scoreboard that the fetch/issue logic reads to stall on read-after-write hazards.

## Interface
- No parameters; fixed at 16 registers × 16 bits, 2-entry ALU holding FIFO.
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; asynchronous, active-low.
- iss_valid  input  1  an instruction with a register destination issues this cycle.
- iss_rd  input  4  destination register of the issuing instruction.
- alu_valid  input  1  ALU result valid this cycle.
- alu_rd  input  4  ALU result destination.
- alu_data  input  16  ALU result value.
- mem_valid  input  1  load result valid this cycle.
- mem_rd  input  4  load destination.
- mem_data  input  16  load value.
- alu_full  output  1  FIFO holds 2 entries; the ALU must not present a result.
- fifo_count  output  2  FIFO occupancy, 0–2.
- en  output  16  one-hot register-file write enable (registered).
- wb_data  output  16  register-file write data (registered).
- busy  output  16  scoreboard; bit k set means a write to register k is pending.
- err  output  1  sticky overflow flag.

## Operation
- One write source is selected per cycle, by priority:
  1. mem_valid.
  2. FIFO head, if fifo_count > 0.
  3. alu_valid, direct bypass, only when FIFO is empty.
- ALU result enqueue: an alu_valid result is pushed into the FIFO when mem_valid is also high, or when the FIFO is non-empty. This preserves ALU write order.
- FIFO push and pop may occur in the same cycle; occupancy is then unchanged.
- Overflow: alu_valid while alu_full with no pop that cycle drops the result, sets err, and leaves busy unchanged. err clears only on reset.
- Register write: the selected write produces en = 1<<rd and wb_data = data. With no source selected, en = 0 and wb_data holds its previous value.
- Scoreboard:
  - busy[iss_rd] sets on an edge where iss_valid = 1.
  - busy[rd] clears on the edge where the write to rd is registered into en.
  - Set and clear of the same bit on the same edge: set wins, because the new issue is pending.
  - Issuing to an already-busy register keeps the bit set; it clears on the next write to that register. The issuer stalls on busy to avoid this case.
- All 16 registers are writable; there is no hardwired-zero register.
- No deduplication: two writes to the same register in consecutive cycles both occur in order.

## Timing
- Reset (rst = 0, asynchronous): en = 0, wb_data = 0, busy = 0, fifo_count = 0, alu_full = 0, err = 0. FIFO contents are don't-care.
- Reset mid-operation discards all queued results and pending busy bits immediately. Outputs hold reset values until the first rising edge after rst returns high.
- Source selection is combinational in cycle N. en and wb_data are registered at the end of cycle N and visible in cycle N+1. The register file captures at the end of cycle N+1.
- Latency: result valid → register updated is 2 edges. A result → busy clear is 1 edge.
- alu_full and fifo_count are registered FIFO state, valid from the start of each cycle. The ALU samples alu_full combinationally.
- A result queued behind a load writes 1 cycle after the load. Worst case is 2 cycles behind the load plus any further consecutive loads; mem_valid can starve the FIFO indefinitely.
- busy is registered and readable by the fetch unit in the cycle after issue.

## Test plan
- Reset: hold rst = 0 with random inputs → en = 0, wb_data = 0, busy = 0, fifo_count = 0, err = 0. Release rst; all outputs stay 0 with no valids.
- ALU bypass:
  - Stimulus: iss_valid, iss_rd = 3; next cycle alu_valid, alu_rd = 3, alu_data = 0x0123.
  - Response: busy[3] = 1 after the issue edge; next cycle en = 0x0008, wb_data = 0x0123, busy[3] = 0.
- Collision:
  - Stimulus: same cycle mem_valid (rd = 7, data 0x4545) and alu_valid (rd = 15, data 0xAEAE).
  - Response: cycle +1: en = 0x0080, wb_data = 0x4545, fifo_count = 1. Cycle +2: en = 0x8000, wb_data = 0xAEAE, fifo_count = 0.
- Ordering and overflow:
  - Stimulus: mem_valid held 3 cycles while alu_valid pushes rd = 1, 2, then a third (rd = 4).
  - Response: alu_full = 1 after the two pushes; the third is dropped and err = 1. After mem_valid drops, writes occur in order: en = 0x0002, then en = 0x0004.
- Scoreboard set/clear conflict: write to rd = 5 registering on the same edge as iss_valid with iss_rd = 5 → busy[5] stays 1.
- Async reset mid-operation: pulse rst low between clock edges with fifo_count = 2 and busy = 0x00A0 → all outputs 0 immediately, without waiting for a clock edge.
